// File: rtl/admm_estimate_convergence_monitor.sv
// Collects one codeword of centered ADMM estimates per iteration, hard-decides them and reports convergence.
// Optional tag consistency check within a word: define ADMM_MONITOR_TAG_CHECK_EN.
module admm_estimate_convergence_monitor #(
  parameter int TAG_WIDTH          = 32,
  parameter int NUM_VARIABLES      = 8,
  parameter int MESSAGE_DATA_WIDTH = 15,
  parameter int INTEGRALITY_MARGIN = 256,
  parameter int MAX_ITERATIONS     = 64,
  localparam int ITER_WIDTH        = $clog2(MAX_ITERATIONS + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ready_in,
  input  logic                          valid_in,
  input  logic [TAG_WIDTH-1:0]          tag_in,
  input  logic [MESSAGE_DATA_WIDTH-1:0] data_in,
  output logic                          busy,
  output logic                          ready_out,
  output logic                          valid_out,
  output logic [TAG_WIDTH-1:0]          tag_out,
  output logic [NUM_VARIABLES-1:0]      decoded_out,
  output logic                          converged,
  output logic                          done,
  output logic [ITER_WIDTH-1:0]         iterations_out,
  output logic                          tag_error
);

  localparam int W         = MESSAGE_DATA_WIDTH;
  localparam int IDX_WIDTH = (NUM_VARIABLES > 1) ? $clog2(NUM_VARIABLES) : 1;
  localparam int HALF      = 1 << (W - 2);
  localparam logic [W:0] THRESHOLD = (W + 1)'(HALF - INTEGRALITY_MARGIN);

  typedef enum logic {COLLECT, OUTPUT} state_t;

  state_t                   state_reg;
  logic [IDX_WIDTH-1:0]     idx_reg;
  logic [ITER_WIDTH-1:0]    iter_reg;
  logic                     all_integral_reg;
  logic [NUM_VARIABLES-1:0] bits_reg;
  logic [TAG_WIDTH-1:0]     tag_reg;

  logic                     accept;
  logic                     last;
  logic signed [W:0]        data_ext;
  logic [W:0]               magnitude;
  logic                     is_integral;
  logic                     hard_bit;
  logic [NUM_VARIABLES-1:0] word_bits;
  logic                     word_integral;
  logic                     word_tag_error;
  logic [ITER_WIDTH-1:0]    iter_next;
  logic [TAG_WIDTH-1:0]     word_tag;
  logic                     converged_next;
  logic                     done_next;

  assign accept    = valid_in & (state_reg == COLLECT);
  assign last      = (idx_reg == IDX_WIDTH'(NUM_VARIABLES - 1));
  assign ready_out = (state_reg == COLLECT);
  assign valid_out = (state_reg == OUTPUT);
  assign busy      = (state_reg == OUTPUT) | (idx_reg != '0);

  // One extra bit keeps |most negative code| representable.
  assign data_ext      = {data_in[W-1], data_in};
  assign magnitude     = data_ext[W] ? (W + 1)'(-data_ext) : (W + 1)'(data_ext);
  assign is_integral   = (magnitude >= THRESHOLD);
  assign hard_bit      = ~data_in[W-1] & (|data_in);
  assign word_integral = all_integral_reg & is_integral;
  assign iter_next     = iter_reg + 1'b1;
  assign word_tag      = (idx_reg == '0) ? tag_in : tag_reg;

  generate
    for (genvar gi = 0; gi < NUM_VARIABLES; gi++) begin : g_slot
      assign word_bits[gi] = (idx_reg == IDX_WIDTH'(gi)) ? hard_bit : bits_reg[gi];
    end
  endgenerate

`ifdef ADMM_MONITOR_TAG_CHECK_EN
  logic tag_error_reg;
  assign word_tag_error = tag_error_reg | ((idx_reg != '0) & (tag_in != tag_reg));
`else
  assign word_tag_error = 1'b0;
  assign tag_error      = 1'b0;
`endif

  // A tag error forces the controller to stop and restart the iteration count.
  assign converged_next = word_integral & ~word_tag_error;
  assign done_next      = converged_next | word_tag_error |
                          (iter_next == ITER_WIDTH'(MAX_ITERATIONS));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= COLLECT;
      idx_reg          <= '0;
      iter_reg         <= '0;
      all_integral_reg <= 1'b1;
      bits_reg         <= '0;
      tag_reg          <= '0;
      tag_out          <= '0;
      decoded_out      <= '0;
      converged        <= 1'b0;
      done             <= 1'b0;
      iterations_out   <= '0;
`ifdef ADMM_MONITOR_TAG_CHECK_EN
      tag_error_reg    <= 1'b0;
      tag_error        <= 1'b0;
`endif
    end else begin
      case (state_reg)
        COLLECT: begin
          if (accept) begin
            bits_reg <= word_bits;
            if (idx_reg == '0) tag_reg <= tag_in;
            if (last) begin
              idx_reg          <= '0;
              iter_reg         <= iter_next;
              all_integral_reg <= 1'b1;
              tag_out          <= word_tag;
              decoded_out      <= word_bits;
              converged        <= converged_next;
              done             <= done_next;
              iterations_out   <= iter_next;
              state_reg        <= OUTPUT;
`ifdef ADMM_MONITOR_TAG_CHECK_EN
              tag_error_reg    <= 1'b0;
              tag_error        <= word_tag_error;
`endif
            end else begin
              idx_reg          <= idx_reg + 1'b1;
              all_integral_reg <= word_integral;
`ifdef ADMM_MONITOR_TAG_CHECK_EN
              tag_error_reg    <= word_tag_error;
`endif
            end
          end
        end
        OUTPUT: begin
          if (ready_in) begin
            state_reg <= COLLECT;
            if (done) iter_reg <= '0;
          end
        end
        default: state_reg <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_admm_estimate_convergence_monitor.sv
// Table-driven scoreboard bench for admm_estimate_convergence_monitor (MAX_ITERATIONS=4).
// Also exercises ADMM_MONITOR_TAG_CHECK_EN when that macro is defined.
module tb_admm_estimate_convergence_monitor;
  localparam int NV     = 8;
  localparam int W      = 15;
  localparam int MAXI   = 4;
  localparam int ITER_W = $clog2(MAXI + 1);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              ready_in = 1'b1;
  logic              valid_in = 1'b0;
  logic [31:0]       tag_in = '0;
  logic [W-1:0]      data_in = '0;
  logic              busy, ready_out, valid_out, converged, done, tag_error;
  logic [31:0]       tag_out;
  logic [NV-1:0]     decoded_out;
  logic [ITER_W-1:0] iterations_out;

  admm_estimate_convergence_monitor #(
    .TAG_WIDTH(32), .NUM_VARIABLES(NV), .MESSAGE_DATA_WIDTH(W),
    .INTEGRALITY_MARGIN(256), .MAX_ITERATIONS(MAXI)
  ) dut (
    .clk(clk), .reset(reset), .ready_in(ready_in), .valid_in(valid_in),
    .tag_in(tag_in), .data_in(data_in), .busy(busy), .ready_out(ready_out),
    .valid_out(valid_out), .tag_out(tag_out), .decoded_out(decoded_out),
    .converged(converged), .done(done), .iterations_out(iterations_out),
    .tag_error(tag_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]      e [NV];
    logic [31:0]       tag;
    logic [NV-1:0]     dec;
    logic              conv;
    logic              dn;
    logic [ITER_W-1:0] iter;
    logic              terr;
  } word_t;

  word_t tbl [13];
  word_t expq [$];
  int checks = 0;
  int failures = 0;
  int words_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  function automatic word_t uni(input int v, input logic [31:0] tag);
    word_t w;
    for (int k = 0; k < NV; k++) w.e[k] = W'(v);
    w.tag = tag; w.dec = '0; w.conv = 0; w.dn = 0; w.iter = '0; w.terr = 0;
    return w;
  endfunction

  function automatic word_t alt(input logic [31:0] tag);
    word_t w = uni(8192, tag);
    for (int k = 1; k < NV; k += 2) w.e[k] = W'(-8192);
    return w;
  endfunction

  function automatic word_t ex(input word_t w, input logic [NV-1:0] dec, input logic conv,
                               input logic dn, input int iter, input logic terr);
    word_t r = w;
    r.dec = dec; r.conv = conv; r.dn = dn; r.iter = ITER_W'(iter); r.terr = terr;
    return r;
  endfunction

  // n < NV drives a partial word (no expectation); tag changes from estimate chg onward if chg >= 0.
  task automatic send_word(input word_t w, input int n, input int chg);
    int budget;
    if (n == NV) expq.push_back(w);
    for (int k = 0; k < n; k++) begin
      valid_in = 1'b1;
      data_in  = w.e[k];
      tag_in   = (chg >= 0 && k >= chg) ? (w.tag ^ 32'h0000_00FF) : w.tag;
      budget = 0;
      while (!ready_out && budget < 50) begin
        @(posedge clk); #1; budget++;
      end
      if (!ready_out) begin
        timeout("ready_out_wait");
        valid_in = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    while (expq.size() != 0 && budget < 100) begin
      @(posedge clk); #1; budget++;
    end
    if (expq.size() != 0) timeout("scoreboard_drain");
  endtask

  initial begin
    word_t w;

    tbl[0] = ex(alt(32'hA000_0000), 8'h55, 1, 1, 1, 0);
    w = alt(32'hA000_0001); w.e[3] = W'(100);
    tbl[1] = ex(w, 8'h5D, 0, 0, 1, 0);
    tbl[2] = ex(alt(32'hA000_0002), 8'h55, 1, 1, 2, 0);
    for (int i = 0; i < 4; i++) begin
      w = uni(8192, 32'hA000_0003 + i); w.e[0] = '0;
      tbl[3 + i] = ex(w, 8'hFE, 0, (i == 3), i + 1, 0);
    end
    tbl[7] = ex(alt(32'hA000_0007), 8'h55, 1, 1, 1, 0);
    w = uni(-8192, 32'hA000_0008); w.e[0] = W'(-7936);
    tbl[8] = ex(w, 8'h00, 1, 1, 1, 0);
    w = uni(-8192, 32'hA000_0009); w.e[0] = W'(-7935);
    tbl[9] = ex(w, 8'h00, 0, 0, 1, 0);
    w = uni(-8192, 32'hA000_000A); w.e[0] = W'(-16384);
    tbl[10] = ex(w, 8'h00, 1, 1, 2, 0);
    w = uni(8192, 32'hA000_000B); w.e[7] = W'(7935);
    tbl[11] = ex(w, 8'hFF, 0, 0, 1, 0);
    w = uni(8192, 32'hA000_000C); w.e[7] = W'(7936);
    tbl[12] = ex(w, 8'hFF, 1, 1, 2, 0);

    fork
      begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
      end
      forever begin
        word_t x;
        @(negedge clk);
        if (!reset && valid_out && ready_in) begin
          if (expq.size() == 0) begin
            timeout("unexpected_word");
          end else begin
            x = expq.pop_front();
            words_seen++;
            $display("word %0d tag=%h decoded=%h conv=%0d done=%0d iter=%0d tag_error=%0d",
                     words_seen, tag_out, decoded_out, converged, done, iterations_out, tag_error);
            check("decoded_out", 64'(decoded_out), 64'(x.dec));
            check("converged", 64'(converged), 64'(x.conv));
            check("done", 64'(done), 64'(x.dn));
            check("iterations_out", 64'(iterations_out), 64'(x.iter));
            check("tag_out", 64'(tag_out), 64'(x.tag));
            check("tag_error", 64'(tag_error), 64'(x.terr));
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_valid_out", 64'(valid_out), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_ready_out", 64'(ready_out), 64'd1);
    check("reset_iterations_out", 64'(iterations_out), 64'd0);
    check("reset_decoded_out", 64'(decoded_out), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 13; i++) send_word(tbl[i], NV, -1);
    drain();

    // Backpressure: hold the status word while stray estimates arrive.
    ready_in = 1'b0;
    send_word(ex(alt(32'hB000_0000), 8'h55, 1, 1, 1, 0), NV, -1);
    for (int c = 0; c < 5; c++) begin
      valid_in = 1'b1;
      data_in  = W'(c * 37);
      tag_in   = 32'hDEAD_0000 + c;
      @(negedge clk);
      check("hold_valid_out", 64'(valid_out), 64'd1);
      check("hold_ready_out", 64'(ready_out), 64'd0);
      check("hold_busy", 64'(busy), 64'd1);
      check("hold_decoded_out", 64'(decoded_out), 64'h55);
      check("hold_iterations_out", 64'(iterations_out), 64'd1);
      check("hold_tag_out", 64'(tag_out), 64'hB000_0000);
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    drain();
    send_word(ex(alt(32'hB000_0001), 8'h55, 1, 1, 1, 0), NV, -1);
    drain();

    // Reset mid-word discards the partial word and the iteration count.
    w = alt(32'hC000_0000); w.e[3] = W'(100);
    send_word(ex(w, 8'h5D, 0, 0, 1, 0), NV, -1);
    drain();
    send_word(alt(32'hC000_0001), 3, -1);
    @(negedge clk);
    check("midword_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_busy", 64'(busy), 64'd0);
    check("post_reset_ready_out", 64'(ready_out), 64'd1);
    @(posedge clk); #1;
    send_word(ex(alt(32'hC000_0002), 8'h55, 1, 1, 1, 0), NV, -1);
    drain();

    // Tag changes at estimate 5.
`ifdef ADMM_MONITOR_TAG_CHECK_EN
    w = alt(32'hC000_0003); w.e[2] = W'(100);
    send_word(ex(w, 8'h55, 0, 1, 1, 1), NV, 5);
    send_word(ex(alt(32'hC000_0004), 8'h55, 1, 1, 1, 0), NV, -1);
`else
    w = alt(32'hC000_0003); w.e[2] = W'(100);
    send_word(ex(w, 8'h55, 0, 0, 1, 0), NV, 5);
    send_word(ex(alt(32'hC000_0004), 8'h55, 1, 1, 2, 0), NV, -1);
`endif
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/admm_estimate_convergence_monitor.md
Name: admm_estimate_convergence_monitor

Overview:
- Sits directly downstream of the centered ADMM variable-node stage.
- Collects one codeword's worth of serial variable estimates per decoder iteration and hard-decides each estimate to a bit.
- Tests whether every estimate is integral, i.e. within a margin of ±1/2.
- Emits one status word per iteration: decoded bits, converged flag, done flag and iteration count. The decoder controller uses this word to stop or continue iterating.

Parameters:
- TAG_WIDTH, 32, width of the tag carried with each estimate.
- NUM_VARIABLES, 8, estimates per codeword (per iteration).
- MESSAGE_DATA_WIDTH, 15, estimate width. Signed, 0 integer bits, fraction = MESSAGE_DATA_WIDTH-1.
- INTEGRALITY_MARGIN, 256, tolerance in estimate LSBs below |1/2| still counted as integral.
- MAX_ITERATIONS, 64, iteration count at which done is forced.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ready_in  in  1  downstream can accept the status word.
- valid_in  in  1  estimate on data_in is valid.
- tag_in  in  TAG_WIDTH  tag of incoming estimate.
- data_in  in  MESSAGE_DATA_WIDTH  signed centered estimate in [-1/2, 1/2].
- busy  out  1  word partially collected or result pending.
- ready_out  out  1  block accepts an estimate this cycle.
- valid_out  out  1  status word valid.
- tag_out  out  TAG_WIDTH  tag of the word's first estimate.
- decoded_out  out  NUM_VARIABLES  hard decisions; estimate k maps to bit k.
- converged  out  1  all estimates of the word integral.
- done  out  1  converged, or iteration limit reached.
- iterations_out  out  ITER_WIDTH  iterations since last done, 1-based.
- tag_error  out  1  tag mismatch within word (see Optional Feature).

Behaviour:
- Interface is fixed: one clock, clk; reset is synchronous and active-high, named reset.
- Local parameters:
  - ITER_WIDTH = ceil(log2(MAX_ITERATIONS+1)).
  - HALF = 2^(MESSAGE_DATA_WIDTH-2), e.g. 8192 at width 15.
- Handshakes:
  - An estimate is accepted when valid_in & ready_out.
  - A status word is consumed when valid_out & ready_in.
- States:
  - COLLECT: ready_out=1, valid_out=0.
    - On each accept: store the hard bit in slot idx, AND the integral test into an all_integral flag, and increment idx.
    - On idx=0, tag_in is captured.
    - On the accept with idx=NUM_VARIABLES-1: idx←0, iter←iter+1, go to OUTPUT.
  - OUTPUT: ready_out=0, valid_out=1.
    - All outputs are held stable until ready_in=1.
    - On consume, go to COLLECT. If done=1, iter←0.
    - ready_out rises the cycle after consume. There is no same-cycle bypass.
- Latency: valid_out asserts the cycle after the last estimate is accepted.
- Hard decision: bit=1 iff estimate > 0. Zero and negative values give 0.
- Integral test: |e| ≥ HALF-INTEGRALITY_MARGIN.
  - |e| is computed in MESSAGE_DATA_WIDTH+1 bits so the most negative code does not overflow.
  - The comparison is inclusive.
- converged = all_integral.
- done = converged | (iter==MAX_ITERATIONS).
- iterations_out = iter value after the increment.
- busy = (state==OUTPUT) | (idx≠0).
- Accepts are never blocked inside COLLECT. valid_in in OUTPUT is ignored and not consumed.
- Reset:
  - state=COLLECT, idx=0, iter=0, all_integral=1.
  - All outputs 0 except ready_out=1.
  - Reset mid-word or mid-OUTPUT discards partial or pending data. The next accepted estimate starts a fresh word with iter counting from 1.
- Registers: decoded_out, tag_out, converged, done and iterations_out are registered outputs. They are updated only on the COLLECT→OUTPUT transition.

Optional Feature:
- Macro: ADMM_MONITOR_TAG_CHECK_EN.
- Defined:
  - Every accept with idx≠0 compares tag_in to the captured tag. A mismatch sets a sticky word error.
  - In the status word: tag_error=1, done=1, converged=0. iter clears on consume.
- Undefined:
  - No comparison logic. tag_error is tied 0.
  - Tags after the first are ignored.

Test Plan:
- Reset: assert reset 2 cycles → valid_out=0, busy=0, ready_out=1, iterations_out=0, decoded_out=0.
- Integral word: 8 estimates alternating +8192,-8192 starting at e0 → next cycle valid_out=1, decoded_out=8'h55, converged=1, done=1, iterations_out=1.
- Non-integral then integral: word with e3=100, others ±8192 → converged=0, done=0, iterations_out=1. Following integral word → iterations_out=2, done=1.
- Limit (MAX_ITERATIONS=4): 4 words each with one estimate = 0 → 4th word done=1, converged=0, iterations_out=4. Next word iterations_out=1.
- Backpressure and boundary: hold ready_in=0 5 cycles in OUTPUT → outputs stable, ready_out=0, valid_in pulses ignored. Word with e0=-7936 → integral. Word with e0=-7935 → not integral. Word with e0=-16384 → integral, bit 0.
- Reset mid-word plus tag check: accept 3 estimates, pulse reset, then send 8 → iterations_out=1. With ADMM_MONITOR_TAG_CHECK_EN, change tag_in at e5 → tag_error=1, done=1, converged=0.
